// File: rtl/sid_pkg.sv
// Shared tt_um_sid sizing: sample width, PWM resolution and the derived carrier period.
package sid_pkg;

  localparam int SID_SAMPLE_W   = 12;
  localparam int SID_PWM_BITS   = 8;
  localparam int SID_PWM_PERIOD = 1 << SID_PWM_BITS;
  localparam int SID_FRAC_W     = SID_SAMPLE_W - SID_PWM_BITS;

  typedef logic [SID_SAMPLE_W-1:0] sid_sample_t;

endpackage

// File: rtl/pwm_noise_shaper.sv
// First-order error-feedback accumulator: integrates the sub-PWM fraction of each sample
// and emits a carry that bumps the duty by one count.
module pwm_noise_shaper #(
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FRAC_W-1:0] frac,
  input  logic              load,
  input  logic              clear,
  output logic              carry
);

  logic [FRAC_W-1:0] err_r;
  logic [FRAC_W:0]   sum_s;

  assign sum_s = {1'b0, err_r} + {1'b0, frac};
  assign carry = sum_s[FRAC_W];

  // Residual error register; cleared while the stage is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= {FRAC_W{1'b0}};
    end else if (clear) begin
      err_r <= {FRAC_W{1'b0}};
    end else if (load) begin
      err_r <= sum_s[FRAC_W-1:0];
    end else begin
      err_r <= err_r;
    end
  end

endmodule

// File: rtl/pwm_audio_out.sv
// Audio output stage: fixed-period PWM carrier whose duty is the noise-shaped sample,
// refreshed only at period boundaries so the output never glitches mid-period.
module pwm_audio_out
  import sid_pkg::*;
#(
  parameter int SAMPLE_W = SID_SAMPLE_W,
  parameter int PWM_BITS = SID_PWM_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_req,
  output logic                pwm_out,
  output logic                overrun,
  output logic                underrun,
  input  logic                clr_flags
);

  localparam int FRAC_W = SAMPLE_W - PWM_BITS;

  logic [PWM_BITS-1:0] cnt_r;
  logic [PWM_BITS-1:0] cnt_nxt_s;
  logic [PWM_BITS:0]   duty_r;
  logic [PWM_BITS:0]   duty_nxt_s;
  logic [PWM_BITS:0]   duty_load_s;
  logic [SAMPLE_W-1:0] pend_r;
  logic [SAMPLE_W-1:0] src_s;
  logic                fresh_r;
  logic                pwm_r;
  logic                overrun_r;
  logic                underrun_r;
  logic                last_s;
  logic                load_s;
  logic                carry_s;
  logic                clear_s;
  logic                set_ov_s;
  logic                set_un_s;

  assign last_s      = (cnt_r == {PWM_BITS{1'b1}});
  assign load_s      = ena & last_s;
  assign clear_s     = ~ena;
  assign src_s       = sample_valid ? sample_in : pend_r;
  assign duty_load_s = {1'b0, src_s[SAMPLE_W-1:FRAC_W]} + {{PWM_BITS{1'b0}}, carry_s};
  assign set_ov_s    = sample_valid & fresh_r;
  assign set_un_s    = load_s & ~fresh_r & ~sample_valid;

  assign sample_req = load_s;
  assign pwm_out    = pwm_r;
  assign overrun    = overrun_r;
  assign underrun   = underrun_r;

  pwm_noise_shaper #(
    .FRAC_W (FRAC_W)
  ) u_shaper (
    .clk   (clk),
    .rst   (rst),
    .frac  (src_s[FRAC_W-1:0]),
    .load  (load_s),
    .clear (clear_s),
    .carry (carry_s)
  );

  // Next counter/duty; duty only changes on the wrap edge so a period is never split.
  always_comb begin
    cnt_nxt_s  = {PWM_BITS{1'b0}};
    duty_nxt_s = {(PWM_BITS+1){1'b0}};
    if (ena) begin
      cnt_nxt_s  = cnt_r + {{(PWM_BITS-1){1'b0}}, 1'b1};
      duty_nxt_s = load_s ? duty_load_s : duty_r;
    end else begin
      cnt_nxt_s  = {PWM_BITS{1'b0}};
      duty_nxt_s = {(PWM_BITS+1){1'b0}};
    end
  end

  // Carrier state; pwm is compared against next-state values so it lines up with cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= {PWM_BITS{1'b0}};
      duty_r <= {(PWM_BITS+1){1'b0}};
      pwm_r  <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      duty_r <= duty_nxt_s;
      pwm_r  <= ({1'b0, cnt_nxt_s} < duty_nxt_s);
    end
  end

  // Pending sample capture, tracked even while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r  <= {1'b1, {(SAMPLE_W-1){1'b0}}};
      fresh_r <= 1'b0;
    end else begin
      if (sample_valid) begin
        pend_r <= sample_in;
      end else begin
        pend_r <= pend_r;
      end
      if (load_s) begin
        fresh_r <= 1'b0;
      end else if (sample_valid) begin
        fresh_r <= 1'b1;
      end else begin
        fresh_r <= fresh_r;
      end
    end
  end

  // Sticky status flags; a same-cycle set beats the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      if (set_ov_s) begin
        overrun_r <= 1'b1;
      end else if (clr_flags) begin
        overrun_r <= 1'b0;
      end else begin
        overrun_r <= overrun_r;
      end
      if (set_un_s) begin
        underrun_r <= 1'b1;
      end else if (clr_flags) begin
        underrun_r <= 1'b0;
      end else begin
        underrun_r <= underrun_r;
      end
    end
  end

endmodule
